// File: rtl/dpa_pattern_checker.sv
`timescale 1ns/1ps
// dpa_pattern_checker
// Receive-side checker for DPA training-pattern frames. It accepts decoded Ethernet
// frames and filters on EtherType. It then aligns to the rotating 20-bit DPA symbol
// pattern and checks every following payload byte and the frame length. Saturating
// statistics are kept for link bring-up and deskew calibration.
//
// Optional feature: define DPA_CHECKER_MAC_FILTER_EN to accept only frames addressed to
// local_mac or to broadcast. When it is undefined, the EtherType alone selects the frame.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   local_mac                   station address for the destination filter
//   s_eth_hdr_*                 frame header (valid/ready, dest/src MAC, EtherType)
//   s_eth_payload_axis_*        payload byte stream (tdata/tvalid/tready/tlast/tuser)
//   stat_clear                  zero all statistics; wins over a same-cycle increment
//   frame_done                  one-cycle pulse after a checked frame ends
//   frame_ok                    result of the last checked frame, held
//   locked                      pattern phase acquired in the current or last frame
//   stat_frames_ok/_bad         clean / failed frame counters
//   stat_byte_errors            mismatching payload bytes after lock
module dpa_pattern_checker #(
  parameter int unsigned DATA_LENGTH = 8192,
  parameter logic [19:0] DPA_PATTERN = 20'b0000_0000_0011_1111_1111,
  parameter logic [15:0] ETH_TYPE    = 16'h88B5,
  parameter int unsigned STAT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [47:0]           local_mac,
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [7:0]            s_eth_payload_axis_tdata,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,
  input  logic                  stat_clear,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic                  locked,
  output logic [STAT_WIDTH-1:0] stat_frames_ok,
  output logic [STAT_WIDTH-1:0] stat_frames_bad,
  output logic [STAT_WIDTH-1:0] stat_byte_errors
);

  localparam int unsigned CNT_W    = $clog2(DATA_LENGTH) + 2;
  localparam int unsigned PAT_SYMS = 10;
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {ST_IDLE, ST_HUNT, ST_CHECK, ST_DROP} state_t;

  state_t                state_q, state_d;
  logic [19:0]           hist_q, hist_d;
  logic [19:0]           exp_q, exp_d;
  logic [3:0]            fill_q, fill_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  locked_q, locked_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_ok_q, frame_ok_d;
  logic                  hdr_ready_q, hdr_ready_d;
  logic                  pay_ready_q, pay_ready_d;
  logic [STAT_WIDTH-1:0] ok_q, ok_d, bad_q, bad_d, berr_q, berr_d;

  logic                  hdr_fire, beat_fire, filter_pass, well_formed;
  logic [1:0]            sym;
  logic [CNT_W-1:0]      cnt_inc;

  function automatic logic [19:0] rotl2(input logic [19:0] v);
    return {v[17:0], v[19:18]};
  endfunction

  // True when v is one of the ten symbol rotations of the training pattern.
  function automatic logic is_rotation(input logic [19:0] v);
    logic [19:0] r;
    logic        hit;
    r   = DPA_PATTERN;
    hit = 1'b0;
    for (int unsigned i = 0; i < PAT_SYMS; i++) begin
      if (v == r) hit = 1'b1;
      r = rotl2(r);
    end
    return hit;
  endfunction

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + STAT_WIDTH'(1);
  endfunction

`ifdef DPA_CHECKER_MAC_FILTER_EN
  assign filter_pass = (s_eth_dest_mac == local_mac) || (s_eth_dest_mac == BCAST_MAC);
  logic unused_src;
  assign unused_src = ^s_eth_src_mac;
`else
  assign filter_pass = 1'b1;
  logic unused_mac;
  assign unused_mac = ^{s_eth_src_mac, s_eth_dest_mac, local_mac, BCAST_MAC};
`endif

  assign hdr_fire  = s_eth_hdr_valid && hdr_ready_q;
  assign beat_fire = s_eth_payload_axis_tvalid && pay_ready_q;

  // Symbol decode: both nibbles must be all-zero or all-one.
  assign well_formed = ((s_eth_payload_axis_tdata[7:4] == 4'h0) || (s_eth_payload_axis_tdata[7:4] == 4'hF)) &&
                       ((s_eth_payload_axis_tdata[3:0] == 4'h0) || (s_eth_payload_axis_tdata[3:0] == 4'hF));
  assign sym     = {s_eth_payload_axis_tdata[7], s_eth_payload_axis_tdata[3]};
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state, datapath and statistics logic.
  always_comb begin
    state_d      = state_q;
    hist_d       = hist_q;
    exp_d        = exp_q;
    fill_d       = fill_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    locked_d     = locked_q;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    ok_d         = ok_q;
    bad_d        = bad_q;
    berr_d       = berr_q;

    case (state_q)
      ST_IDLE: begin
        if (hdr_fire) begin
          state_d  = ((s_eth_type == ETH_TYPE) && filter_pass) ? ST_HUNT : ST_DROP;
          cnt_d    = '0;
          fill_d   = '0;
          locked_d = 1'b0;
          err_d    = 1'b0;
        end
      end
      ST_HUNT: begin
        if (beat_fire) begin
          cnt_d  = cnt_inc;
          hist_d = {hist_q[17:0], sym};
          if (!well_formed)                 fill_d = '0;
          else if (fill_q != 4'(PAT_SYMS))  fill_d = fill_q + 4'd1;
          // The freshly shifted history already holds the next expected symbol at its top.
          if (!s_eth_payload_axis_tlast && well_formed && (fill_d == 4'(PAT_SYMS)) && is_rotation(hist_d)) begin
            exp_d    = hist_d;
            locked_d = 1'b1;
            state_d  = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (beat_fire) begin
          cnt_d = cnt_inc;
          exp_d = rotl2(exp_q);
          if (!well_formed || (sym != exp_q[19:18])) begin
            err_d  = 1'b1;
            berr_d = sat_inc(berr_q);
          end
        end
      end
      ST_DROP: begin
        if (beat_fire && s_eth_payload_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame end for checked frames; the last byte is already included in cnt_d and err_d.
    if (((state_q == ST_HUNT) || (state_q == ST_CHECK)) && beat_fire && s_eth_payload_axis_tlast) begin
      frame_done_d = 1'b1;
      frame_ok_d   = locked_q && !err_d && !s_eth_payload_axis_tuser && (cnt_d == CNT_W'(DATA_LENGTH));
      if (frame_ok_d) ok_d  = sat_inc(ok_q);
      else            bad_d = sat_inc(bad_q);
      state_d = ST_IDLE;
    end

    if (stat_clear) begin
      ok_d   = '0;
      bad_d  = '0;
      berr_d = '0;
    end

    hdr_ready_d = (state_d == ST_IDLE);
    pay_ready_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hist_q       <= '0;
      exp_q        <= '0;
      fill_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      hdr_ready_q  <= 1'b1;
      pay_ready_q  <= 1'b0;
      ok_q         <= '0;
      bad_q        <= '0;
      berr_q       <= '0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      exp_q        <= exp_d;
      fill_q       <= fill_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      locked_q     <= locked_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      hdr_ready_q  <= hdr_ready_d;
      pay_ready_q  <= pay_ready_d;
      ok_q         <= ok_d;
      bad_q        <= bad_d;
      berr_q       <= berr_d;
    end
  end

  assign s_eth_hdr_ready           = hdr_ready_q;
  assign s_eth_payload_axis_tready = pay_ready_q;
  assign frame_done                = frame_done_q;
  assign frame_ok                  = frame_ok_q;
  assign locked                    = locked_q;
  assign stat_frames_ok            = ok_q;
  assign stat_frames_bad           = bad_q;
  assign stat_byte_errors          = berr_q;

endmodule
